// File: rtl/gate_checker_pkg.sv
// ============================================================================
// gate_checker_pkg : shared state encoding, gate channel indices, popcount
// Rev 1.0
// ============================================================================
`default_nettype none

package gate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int GATE_NOT  = 0;
  localparam int GATE_NAND = 1;
  localparam int GATE_FLOP = 2;
  localparam int GATE_MUX  = 3;
  localparam int GATE_MUX4 = 4;
  localparam int NUM_GATES = 5;

  function automatic logic [2:0] popcount5(input logic [NUM_GATES-1:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < NUM_GATES; i++) begin
      s = s + {2'b00, v[i]};
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_checker_ref_model.sv
// ============================================================================
// gate_ref_model : golden model of the gate test set (not, nand, flop, muxes)
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_checker_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic       i_in_not,
  input  logic       i_in1_nand,
  input  logic       i_in2_nand,
  input  logic       i_d_flop,
  input  logic       i_a_mux,
  input  logic       i_b_mux,
  input  logic       i_s_mux,
  input  logic       i_reset_l_mux,
  input  logic [3:0] i_a4,
  input  logic [3:0] i_b4,
  input  logic       i_s4,
  input  logic       i_reset_l4,
  output logic       o_exp_not,
  output logic       o_exp_nand,
  output logic       o_exp_flop,
  output logic       o_exp_mux,
  output logic [3:0] o_exp_mux4
);

  logic       r_exp_flop;
  logic       r_exp_mux;
  logic [3:0] r_exp_mux4;

  assign o_exp_not  = ~i_in_not;
  assign o_exp_nand = ~(i_in1_nand & i_in2_nand);

  // The mux models carry their own synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_exp_flop <= 1'b0;
      r_exp_mux  <= 1'b0;
      r_exp_mux4 <= 4'b0;
    end else begin
      r_exp_flop <= i_d_flop;
      r_exp_mux  <= i_reset_l_mux ? (i_s_mux ? i_b_mux : i_a_mux) : 1'b0;
      r_exp_mux4 <= i_reset_l4 ? (i_s4 ? i_b4 : i_a4) : 4'b0;
    end
  end

  assign o_exp_flop = r_exp_flop;
  assign o_exp_mux  = r_exp_mux;
  assign o_exp_mux4 = r_exp_mux4;

endmodule

`default_nettype wire

// File: rtl/gate_checker.sv
// ============================================================================
// gate_checker : compares gate DUT responses against a golden model over a run
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int WARMUP_CYCLES = 2,
  parameter int CHECK_CYCLES  = 8,
  parameter int CNT_W         = 8,
  parameter int CYC_W         = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             in_not,
  input  logic             in1_nand,
  input  logic             in2_nand,
  input  logic             D_flop,
  input  logic             A_mux,
  input  logic             B_mux,
  input  logic             S_mux,
  input  logic             Reset_L_mux,
  input  logic [3:0]       A4,
  input  logic [3:0]       B4,
  input  logic             S4,
  input  logic             Reset_L4,
  input  logic             out_not,
  input  logic             out_nand,
  input  logic             Q_flop,
  input  logic             Q_mux,
  input  logic [3:0]       Q4,
  output logic             done,
  output logic             pass,
  output logic [4:0]       err_mask,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CYC_W-1:0] first_err_cycle,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int PH_W  = 16;
  localparam int SUM_W = ((CNT_W > 3) ? CNT_W : 3) + 1;
  localparam logic [PH_W-1:0] PH_WARM_LAST  = PH_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [PH_W-1:0] PH_CHECK_LAST = PH_W'((CHECK_CYCLES > 0) ? CHECK_CYCLES - 1 : 0);
  localparam state_t RUN_ENTRY = (WARMUP_CYCLES == 0) ? ST_CHECK : ST_WARMUP;

  state_t                 r_state, w_state_next;
  logic [PH_W-1:0]        r_phase;
  logic                   w_start_run;
  logic                   w_exp_not, w_exp_nand, w_exp_flop, w_exp_mux;
  logic [3:0]             w_exp_mux4;
  logic [NUM_GATES-1:0]   w_mis;
  logic [SUM_W-1:0]       w_sum;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [CYC_W-1:0]       w_cyc_inc;

  logic                   r_done, r_pass, r_first_err_valid;
  logic [4:0]             r_err_mask;
  logic [CNT_W-1:0]       r_err_count;
  logic [CYC_W-1:0]       r_first_err_cycle, r_cycle_count;

  gate_ref_model u_ref (
    .clk          (clk),
    .Reset        (Reset),
    .i_in_not     (in_not),
    .i_in1_nand   (in1_nand),
    .i_in2_nand   (in2_nand),
    .i_d_flop     (D_flop),
    .i_a_mux      (A_mux),
    .i_b_mux      (B_mux),
    .i_s_mux      (S_mux),
    .i_reset_l_mux(Reset_L_mux),
    .i_a4         (A4),
    .i_b4         (B4),
    .i_s4         (S4),
    .i_reset_l4   (Reset_L4),
    .o_exp_not    (w_exp_not),
    .o_exp_nand   (w_exp_nand),
    .o_exp_flop   (w_exp_flop),
    .o_exp_mux    (w_exp_mux),
    .o_exp_mux4   (w_exp_mux4)
  );

  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_next = RUN_ENTRY;
      ST_WARMUP:        if (r_phase == PH_WARM_LAST) w_state_next = ST_CHECK;
      ST_CHECK:         if (r_phase == PH_CHECK_LAST) w_state_next = ST_DONE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) r_phase <= '0;
      else if ((r_state == ST_WARMUP) || (r_state == ST_CHECK)) r_phase <= r_phase + PH_W'(1);
    end
  end

  // Case inequality so an X/Z on a DUT response counts as a mismatch.
  always_comb begin
    w_mis = '0;
    if (r_state == ST_CHECK) begin
      w_mis[GATE_NOT]  = (out_not  !== w_exp_not);
      w_mis[GATE_NAND] = (out_nand !== w_exp_nand);
      w_mis[GATE_FLOP] = (Q_flop   !== w_exp_flop);
      w_mis[GATE_MUX]  = (Q_mux    !== w_exp_mux);
      w_mis[GATE_MUX4] = (Q4       !== w_exp_mux4);
    end
  end

  assign w_sum      = SUM_W'(r_err_count) + SUM_W'(popcount5(w_mis));
  assign w_cnt_next = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign w_cyc_inc  = (r_cycle_count == {CYC_W{1'b1}}) ? r_cycle_count : r_cycle_count + CYC_W'(1);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_mask        <= '0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_cycle <= '0;
      r_cycle_count     <= '0;
    end else if (w_start_run) begin
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_mask        <= '0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_cycle <= '0;
      r_cycle_count     <= '0;
    end else begin
      if ((r_state == ST_WARMUP) || (r_state == ST_CHECK)) r_cycle_count <= w_cyc_inc;
      if (r_state == ST_CHECK) begin
        r_err_mask  <= r_err_mask | w_mis;
        r_err_count <= w_cnt_next;
        if ((|w_mis) && !r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_cycle <= r_cycle_count;
        end
        // pass must include any mismatch found on the final compare edge.
        if (w_state_next == ST_DONE) begin
          r_done <= 1'b1;
          r_pass <= (w_cnt_next == '0);
        end
      end
    end
  end

  assign done            = r_done;
  assign pass            = r_pass;
  assign err_mask        = r_err_mask;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_err_valid;
  assign first_err_cycle = r_first_err_cycle;
  assign cycle_count     = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_gate_checker.sv
// ============================================================================
// tb_gate_checker : table-driven runs plus restart, saturation and abort cases
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gate_checker;

  localparam int W = 2;
  localparam int C = 8;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] idx = 8'd0;

  // fault configuration for the current run
  bit cfg_nand_stuck = 0;
  int cfg_nand_from = 0, cfg_nand_len = 0;
  bit cfg_flop_dly = 0;
  int cfg_mux_at = -1;
  int cfg_not_from = 0, cfg_not_len = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // stimulus derived from the per-edge index
  logic in_not, in1_nand, in2_nand, D_flop, A_mux, B_mux, S_mux, Reset_L_mux, S4, Reset_L4;
  logic [3:0] A4, B4;
  logic nand_win, not_win, mux_hit;
  assign nand_win    = (int'(idx) >= cfg_nand_from) && (int'(idx) < cfg_nand_from + cfg_nand_len);
  assign not_win     = (int'(idx) >= cfg_not_from) && (int'(idx) < cfg_not_from + cfg_not_len);
  assign mux_hit     = (int'(idx) == cfg_mux_at);
  assign in_not      = idx[0];
  assign in1_nand    = cfg_nand_stuck ? nand_win : idx[1];
  assign in2_nand    = cfg_nand_stuck ? nand_win : idx[0];
  assign D_flop      = idx[0];
  assign A_mux       = idx[1];
  assign B_mux       = ~idx[0];
  assign S_mux       = idx[2];
  assign Reset_L_mux = (idx != 8'd5);
  assign A4          = idx[3:0];
  assign B4          = ~idx[3:0];
  assign S4          = idx[0];
  assign Reset_L4    = (idx != 8'd7);

  // ideal gate DUTs
  logic m_flop = 1'b0, m_flop_d2 = 1'b0, m_mux = 1'b0;
  logic [3:0] m_q4 = 4'b0;
  always @(posedge clk) begin
    m_flop    <= D_flop;
    m_flop_d2 <= m_flop;
    m_mux     <= Reset_L_mux ? (S_mux ? B_mux : A_mux) : 1'b0;
    m_q4      <= Reset_L4 ? (S4 ? B4 : A4) : 4'b0;
  end

  logic out_not, out_nand, Q_flop, Q_mux;
  logic [3:0] Q4;
  assign out_not  = ~in_not ^ not_win;
  assign out_nand = cfg_nand_stuck ? 1'b1 : ~(in1_nand & in2_nand);
  assign Q_flop   = cfg_flop_dly ? m_flop_d2 : m_flop;
  assign Q_mux    = m_mux ^ mux_hit;
  assign Q4       = m_q4 ^ (mux_hit ? 4'b0110 : 4'b0000);

  logic done, pass, fv;
  logic [4:0] mask;
  logic [7:0] cnt, fc, cyc;

  gate_checker #(.WARMUP_CYCLES(W), .CHECK_CYCLES(C), .CNT_W(8), .CYC_W(8)) dut (
    .clk(clk), .Reset(Reset), .start(start),
    .in_not(in_not), .in1_nand(in1_nand), .in2_nand(in2_nand), .D_flop(D_flop),
    .A_mux(A_mux), .B_mux(B_mux), .S_mux(S_mux), .Reset_L_mux(Reset_L_mux),
    .A4(A4), .B4(B4), .S4(S4), .Reset_L4(Reset_L4),
    .out_not(out_not), .out_nand(out_nand), .Q_flop(Q_flop), .Q_mux(Q_mux), .Q4(Q4),
    .done(done), .pass(pass), .err_mask(mask), .err_count(cnt),
    .first_err_valid(fv), .first_err_cycle(fc), .cycle_count(cyc)
  );

  // second checker with a 2-bit counter, fed responses that are always wrong
  logic done2, pass2, fv2;
  logic [4:0] mask2;
  logic [1:0] cnt2;
  logic [7:0] fc2, cyc2;

  gate_checker #(.WARMUP_CYCLES(W), .CHECK_CYCLES(C), .CNT_W(2), .CYC_W(8)) dut2 (
    .clk(clk), .Reset(Reset), .start(start),
    .in_not(in_not), .in1_nand(in1_nand), .in2_nand(in2_nand), .D_flop(D_flop),
    .A_mux(A_mux), .B_mux(B_mux), .S_mux(S_mux), .Reset_L_mux(Reset_L_mux),
    .A4(A4), .B4(B4), .S4(S4), .Reset_L4(Reset_L4),
    .out_not(in_not), .out_nand(in1_nand & in2_nand), .Q_flop(~m_flop), .Q_mux(~m_mux), .Q4(~m_q4),
    .done(done2), .pass(pass2), .err_mask(mask2), .err_count(cnt2),
    .first_err_valid(fv2), .first_err_cycle(fc2), .cycle_count(cyc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       nand_stuck;
    int       nand_from;
    int       nand_len;
    bit       flop_dly;
    int       mux_at;
    int       not_from;
    int       not_len;
    logic [4:0] e_mask;
    int       e_cnt;
    bit       e_fv;
    int       e_fc;
    bit       e_pass;
  } vec_t;

  vec_t tbl[6];

  task automatic set_cfg(input vec_t v);
    cfg_nand_stuck = v.nand_stuck;
    cfg_nand_from  = v.nand_from;
    cfg_nand_len   = v.nand_len;
    cfg_flop_dly   = v.flop_dly;
    cfg_mux_at     = v.mux_at;
    cfg_not_from   = v.not_from;
    cfg_not_len    = v.not_len;
  endtask

  // start on E0, stimulus index j-1 is applied before edge Ej
  task automatic run_one(input vec_t v, input int id);
    set_cfg(v);
    @(negedge clk);
    start = 1'b1;
    idx = 8'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("r%0d restart cnt", id), 32'(cnt), 32'd0);
    chk($sformatf("r%0d restart cnt2", id), 32'(cnt2), 32'd0);
    chk($sformatf("r%0d restart pass", id), 32'(pass), 32'd0);
    for (int j = 1; j <= W + C; j++) begin
      @(posedge clk);
      @(negedge clk);
      idx = 8'(j);
      if (j == W + C - 1) chk($sformatf("r%0d done early", id), 32'(done), 32'd0);
    end
    chk($sformatf("r%0d done", id), 32'(done), 32'd1);
    chk($sformatf("r%0d pass", id), 32'(pass), 32'(v.e_pass));
    chk($sformatf("r%0d err_mask", id), 32'(mask), 32'(v.e_mask));
    chk($sformatf("r%0d err_count", id), 32'(cnt), 32'(v.e_cnt));
    chk($sformatf("r%0d first_valid", id), 32'(fv), 32'(v.e_fv));
    chk($sformatf("r%0d first_cycle", id), 32'(fc), 32'(v.e_fc));
    chk($sformatf("r%0d cycle_count", id), 32'(cyc), 32'd10);
    chk($sformatf("r%0d sat cnt2", id), 32'(cnt2), 32'd3);
    chk($sformatf("r%0d sat mask2", id), 32'(mask2), 32'h1f);
  endtask

  initial begin
    //        nst from len dly mux nfr nln  mask      cnt fv fc pass
    tbl[0] = '{0, 0, 0, 0, -1, 0, 0, 5'b00000, 0, 0, 0, 1};
    tbl[1] = '{1, 4, 3, 0, -1, 0, 0, 5'b00010, 3, 1, 4, 0};
    tbl[2] = '{0, 0, 0, 1, -1, 0, 0, 5'b00100, 8, 1, 2, 0};
    tbl[3] = '{0, 0, 0, 0,  6, 0, 0, 5'b11000, 2, 1, 6, 0};
    tbl[4] = '{0, 0, 0, 0, -1, 0, 2, 5'b00000, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 0, -1, 9, 1, 5'b00001, 1, 1, 9, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset done", 32'(done), 32'd0);
    chk("reset pass", 32'(pass), 32'd0);
    chk("reset mask", 32'(mask), 32'd0);
    chk("reset cnt", 32'(cnt), 32'd0);
    chk("reset fv", 32'(fv), 32'd0);
    chk("reset cyc", 32'(cyc), 32'd0);
    Reset = 1'b0;

    for (int r = 0; r < 6; r++) run_one(tbl[r], r);

    // start pulsed in CHECK is ignored, then reset aborts the run
    set_cfg('{1, 3, 1, 0, -1, 0, 0, 5'b0, 0, 0, 0, 0});
    @(negedge clk);
    start = 1'b1;
    idx = 8'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      if (j == 5) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      idx = 8'(j);
    end
    chk("ignore start cyc", 32'(cyc), 32'd5);
    chk("ignore start cnt", 32'(cnt), 32'd1);
    chk("ignore start fc", 32'(fc), 32'd3);
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    chk("abort done", 32'(done), 32'd0);
    chk("abort cnt", 32'(cnt), 32'd0);
    chk("abort mask", 32'(mask), 32'd0);
    chk("abort fv", 32'(fv), 32'd0);
    chk("abort cyc", 32'(cyc), 32'd0);
    chk("abort cnt2", 32'(cnt2), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle cyc", 32'(cyc), 32'd0);
    chk("idle done", 32'(done), 32'd0);

    run_one(tbl[0], 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
